mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning max wait cycles for mem_ready (0 = no timeout).
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of retired-instruction counter.
REQ-003 SHALL have parameter EN_EXT, default 1, meaning enable JAL/JR/ADDI/ANDI/SLTI (0 = treat as illegal).
REQ-004 Ports: clk input 1 (single clock); rst input 1 (synchronous, active-high).
REQ-005 Ports: opcode in 6 (IR[31:26]); funct in 6 (IR[5:0]); zero in 1 (ALU zero); mem_ready in 1 (memory access complete this cycle).
REQ-006 Ports: alu_src_a out 1; alu_src_b out 2 (00 B, 01 const 4, 10 sext imm, 11 sext imm<<2); alu_op out 2 (00 add, 01 sub, 10 funct, 11 opcode-immediate).
REQ-007 Ports: mem_read, mem_write, reg_write, ir_write, iord, pc_write, pc_write_cond_beq, pc_write_cond_bne out 1 each.
REQ-008 Ports: pc_src out 2 (00 ALU, 01 ALUOut, 10 jump target, 11 register A); reg_dst out 2 (00 rt, 01 rd, 10 $31); mem_to_reg out 2 (00 ALUOut, 01 MDR, 10 PC).
REQ-009 Ports: instr_done out 1 (retire pulse); retire_cnt out CNT_W; err out 1 (sticky trap); state_dbg out 5.

Function
REQ-010 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, IEXEC, IWB, BEQ, BNE, JUMP, JAL, JR, TRAP.
REQ-011 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write and pc_write SHALL assert only in the cycle mem_ready=1, then -> DECODE; else stay.
REQ-012 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next by opcode: 100011/101011 -> MEMADR; 000000 with funct 001000 -> JR (EN_EXT=1); other 000000 -> RTEXEC; 000100 -> BEQ; 000101 -> BNE; 000010 -> JUMP; 000011 -> JAL; 001000/001100/001010 -> IEXEC; anything else -> TRAP.
REQ-013 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; -> MEMRD if lw, MEMWR if sw.
REQ-014 MEMRD: mem_read=1, iord=1; stay until mem_ready, then -> MEMWB. MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01; -> FETCH.
REQ-015 MEMWR: mem_write=1, iord=1; stay until mem_ready, then -> FETCH.
REQ-016 RTEXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> RTWB: reg_write=1, reg_dst=01, mem_to_reg=00 -> FETCH.
REQ-017 IEXEC: alu_src_a=1, alu_src_b=10, alu_op=11 -> IWB: reg_write=1, reg_dst=00, mem_to_reg=00 -> FETCH.
REQ-018 BEQ/BNE: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write_cond_beq (resp. _bne)=1 -> FETCH.
REQ-019 JUMP: pc_write=1, pc_src=10. JAL: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10. JR: pc_write=1, pc_src=11. All -> FETCH.
REQ-020 Outputs not listed for a state SHALL be 0; outputs are combinational from state and mem_ready only.
REQ-021 Wait timer SHALL count consecutive cycles in FETCH/MEMRD/MEMWR with mem_ready=0; reaching MEM_TIMEOUT (if nonzero) SHALL move to TRAP; timer clears on mem_ready or state change.
REQ-022 TRAP: all strobes 0, err=1, held until rst.
REQ-023 instr_done SHALL pulse 1 cycle in the cycle a final state (MEMWB, MEMWR with mem_ready, RTWB, IWB, BEQ, BNE, JUMP, JAL, JR) transitions to FETCH; retire_cnt increments same edge, wraps at 2^CNT_W.
REQ-024 state_dbg SHALL present the current state encoding.

Reset
REQ-025 rst high at a clock edge SHALL force state FETCH, timer 0, retire_cnt 0, err 0, regardless of current state or pending memory access.
REQ-026 While rst is high all strobe outputs SHALL be 0 and instr_done 0.

Structure
REQ-027 Package mc_ctrl_pkg SHALL hold the state enum, opcode/funct constants, and the alu_src_b/alu_op/pc_src/reg_dst/mem_to_reg encodings.
REQ-028 Sub-module mem_wait_timer SHALL implement the REQ-021 timer and timeout flag.

Verification
REQ-029 add (op 0, funct 100000), mem_ready=1 always -> FETCH,DECODE,RTEXEC,RTWB; reg_write=1 reg_dst=01 in cycle 4; instr_done pulse; retire_cnt=1.
REQ-030 lw with mem_ready delayed 3 cycles in MEMRD -> mem_read/iord held 3 cycles, MEMWB follows, 7 cycles total FETCH-to-FETCH.
REQ-031 beq zero=1 and bne zero=0 -> pc_write_cond_beq/_bne asserted with pc_src=01, 3 cycles each.
REQ-032 jal -> reg_dst=10, mem_to_reg=10, pc_src=10 in one cycle; EN_EXT=0 build -> jal reaches TRAP, err=1.
REQ-033 MEM_TIMEOUT=4, mem_ready=0 in FETCH -> TRAP after 4 cycles, err=1; rst pulse -> FETCH, err=0, retire_cnt=0.
REQ-034 Opcode 111111 -> TRAP after DECODE; rst asserted mid-MEMWR -> no write strobe next cycle, state FETCH.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state encoding,
// instruction field constants, datapath select encodings, control bundle.
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH  = 5'd0,
    S_DECODE = 5'd1,
    S_MEMADR = 5'd2,
    S_MEMRD  = 5'd3,
    S_MEMWB  = 5'd4,
    S_MEMWR  = 5'd5,
    S_RTEXEC = 5'd6,
    S_RTWB   = 5'd7,
    S_IEXEC  = 5'd8,
    S_IWB    = 5'd9,
    S_BEQ    = 5'd10,
    S_BNE    = 5'd11,
    S_JUMP   = 5'd12,
    S_JAL    = 5'd13,
    S_JR     = 5'd14,
    S_TRAP   = 5'd15
  } state_t;

  // Opcode (IR[31:26]) and funct (IR[5:0]) values
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // ALU operand B select
  localparam logic [1:0] ALUB_B       = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  // Next-PC source
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  // Register-file write address select
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  // Register-file write data select
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // One bundle for every datapath control output
  typedef struct packed {
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       ir_write;
    logic       iord;
    logic       pc_write;
    logic       pc_write_cond_beq;
    logic       pc_write_cond_bne;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
  } ctrl_t;

  // Instruction dispatch out of DECODE; extension ops trap when disabled
  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn,
                                         input bit en_ext);
    state_t s;
    case (op)
      OP_LW, OP_SW: s = S_MEMADR;
      OP_RTYPE: begin
        if (fn == FN_JR) begin
          s = en_ext ? S_JR : S_TRAP;
        end else begin
          s = S_RTEXEC;
        end
      end
      OP_BEQ:                   s = S_BEQ;
      OP_BNE:                   s = S_BNE;
      OP_J:                     s = S_JUMP;
      OP_JAL:                   s = en_ext ? S_JAL : S_TRAP;
      OP_ADDI, OP_ANDI, OP_SLTI: s = en_ext ? S_IEXEC : S_TRAP;
      default:                  s = S_TRAP;
    endcase
    return s;
  endfunction

  // States whose exit to FETCH retires an instruction
  function automatic logic is_final(input state_t s);
    logic f;
    case (s)
      S_MEMWB, S_MEMWR, S_RTWB, S_IWB, S_BEQ, S_BNE, S_JUMP, S_JAL, S_JR: f = 1'b1;
      default: f = 1'b0;
    endcase
    return f;
  endfunction

  // States that stall on mem_ready
  function automatic logic is_wait(input state_t s);
    logic w;
    case (s)
      S_FETCH, S_MEMRD, S_MEMWR: w = 1'b1;
      default:                   w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory-stall cycles and flags a timeout in the cycle
// the stall length reaches MEM_TIMEOUT (0 disables the timeout).
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_wait,
  input  logic i_mem_ready,
  output logic o_timeout
);

  localparam int unsigned TW        = (MEM_TIMEOUT < 32'd1) ? 1 : $clog2(MEM_TIMEOUT + 32'd1);
  localparam int unsigned LIMIT_INT = (MEM_TIMEOUT == 32'd0) ? 32'd0 : (MEM_TIMEOUT - 32'd1);
  localparam logic [TW-1:0] LIMIT   = TW'(LIMIT_INT);
  localparam bit ENABLED            = (MEM_TIMEOUT != 32'd0);

  logic [TW-1:0] r_cnt;
  logic          w_stall;
  logic          w_timeout;

  // Stall detection and timeout compare; the count already holds the
  // number of earlier stalled cycles, so the limit is MEM_TIMEOUT-1
  always_comb begin
    w_stall   = i_wait & ~i_mem_ready;
    w_timeout = ENABLED & w_stall & (r_cnt == LIMIT);
  end

  // Stall counter: advances while stalled, clears on ready, state exit or timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (ENABLED && w_stall && !w_timeout) begin
      r_cnt <= r_cnt + TW'(1'b1);
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_timeout = w_timeout;

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute states,
// drives datapath strobes, counts retired instructions, traps on illegal
// opcodes and memory timeouts.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32,
  parameter bit          EN_EXT      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             ir_write,
  output logic             iord,
  output logic             pc_write,
  output logic             pc_write_cond_beq,
  output logic             pc_write_cond_bne,
  output logic [1:0]       pc_src,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             instr_done,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             err,
  output logic [4:0]       state_dbg
);

  state_t           r_state;
  state_t           w_next;
  logic             r_err;
  logic [CNT_W-1:0] r_retire_cnt;
  logic             w_timeout;
  logic             w_retire;
  ctrl_t            w_ctrl;
  ctrl_t            w_ctrl_out;
  logic             w_unused_zero;

  // Branch resolution on zero happens in the datapath, not here
  assign w_unused_zero = zero;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .i_wait      (is_wait(r_state)),
    .i_mem_ready (mem_ready),
    .o_timeout   (w_timeout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; timeout and mem_ready are mutually exclusive
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_timeout)      w_next = S_TRAP;
        else if (mem_ready) w_next = S_DECODE;
        else                w_next = S_FETCH;
      end
      S_DECODE: w_next = decode_next(opcode, funct, EN_EXT);
      S_MEMADR: begin
        if (opcode == OP_LW)      w_next = S_MEMRD;
        else if (opcode == OP_SW) w_next = S_MEMWR;
        else                      w_next = S_TRAP;
      end
      S_MEMRD: begin
        if (w_timeout)      w_next = S_TRAP;
        else if (mem_ready) w_next = S_MEMWB;
        else                w_next = S_MEMRD;
      end
      S_MEMWR: begin
        if (w_timeout)      w_next = S_TRAP;
        else if (mem_ready) w_next = S_FETCH;
        else                w_next = S_MEMWR;
      end
      S_RTEXEC: w_next = S_RTWB;
      S_IEXEC:  w_next = S_IWB;
      S_MEMWB, S_RTWB, S_IWB, S_BEQ, S_BNE, S_JUMP, S_JAL, S_JR: w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_TRAP;
    endcase
  end

  // Per-state control decode (Moore, except FETCH's mem_ready-qualified writes)
  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = ALUB_FOUR;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_ctrl.pc_src    = PCSRC_ALU;
        w_ctrl.ir_write  = mem_ready;
        w_ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        w_ctrl.alu_src_b = ALUB_IMM_SH2;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = ALUB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = REGDST_RT;
        w_ctrl.mem_to_reg = M2R_MDR;
      end
      S_MEMWR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.iord      = 1'b1;
      end
      S_RTEXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = ALUB_B;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = REGDST_RD;
        w_ctrl.mem_to_reg = M2R_ALUOUT;
      end
      S_IEXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = ALUB_IMM;
        w_ctrl.alu_op    = ALUOP_IMM;
      end
      S_IWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = REGDST_RT;
        w_ctrl.mem_to_reg = M2R_ALUOUT;
      end
      S_BEQ: begin
        w_ctrl.alu_src_a         = 1'b1;
        w_ctrl.alu_src_b         = ALUB_B;
        w_ctrl.alu_op            = ALUOP_SUB;
        w_ctrl.pc_src            = PCSRC_ALUOUT;
        w_ctrl.pc_write_cond_beq = 1'b1;
      end
      S_BNE: begin
        w_ctrl.alu_src_a         = 1'b1;
        w_ctrl.alu_src_b         = ALUB_B;
        w_ctrl.alu_op            = ALUOP_SUB;
        w_ctrl.pc_src            = PCSRC_ALUOUT;
        w_ctrl.pc_write_cond_bne = 1'b1;
      end
      S_JUMP: begin
        w_ctrl.pc_write = 1'b1;
        w_ctrl.pc_src   = PCSRC_JUMP;
      end
      S_JAL: begin
        w_ctrl.pc_write   = 1'b1;
        w_ctrl.pc_src     = PCSRC_JUMP;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = REGDST_RA;
        w_ctrl.mem_to_reg = M2R_PC;
      end
      S_JR: begin
        w_ctrl.pc_write = 1'b1;
        w_ctrl.pc_src   = PCSRC_REGA;
      end
      S_TRAP:  w_ctrl = '0;
      default: w_ctrl = '0;
    endcase
  end

  // Retire when a final state hands back to FETCH; reset suppresses it
  assign w_retire = ~rst & is_final(r_state) & (w_next == S_FETCH);

  // Reset forces every strobe low so no access can complete under reset
  assign w_ctrl_out = rst ? ctrl_t'('0) : w_ctrl;

  // Sticky error flag and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err        <= 1'b0;
      r_retire_cnt <= '0;
    end else begin
      if (w_next == S_TRAP) begin
        r_err <= 1'b1;
      end else begin
        r_err <= r_err;
      end
      if (w_retire) begin
        r_retire_cnt <= r_retire_cnt + CNT_W'(1'b1);
      end else begin
        r_retire_cnt <= r_retire_cnt;
      end
    end
  end

  assign alu_src_a         = w_ctrl_out.alu_src_a;
  assign alu_src_b         = w_ctrl_out.alu_src_b;
  assign alu_op            = w_ctrl_out.alu_op;
  assign mem_read          = w_ctrl_out.mem_read;
  assign mem_write         = w_ctrl_out.mem_write;
  assign reg_write         = w_ctrl_out.reg_write;
  assign ir_write          = w_ctrl_out.ir_write;
  assign iord              = w_ctrl_out.iord;
  assign pc_write          = w_ctrl_out.pc_write;
  assign pc_write_cond_beq = w_ctrl_out.pc_write_cond_beq;
  assign pc_write_cond_bne = w_ctrl_out.pc_write_cond_bne;
  assign pc_src            = w_ctrl_out.pc_src;
  assign reg_dst           = w_ctrl_out.reg_dst;
  assign mem_to_reg        = w_ctrl_out.mem_to_reg;
  assign instr_done        = w_retire;
  assign retire_cnt        = r_retire_cnt;
  assign err               = r_err;
  assign state_dbg         = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm. Instance A uses default parameters;
// instance B (MEM_TIMEOUT=4, CNT_W=2, EN_EXT=0) shares the same stimulus and
// covers timeout, counter wrap and disabled extension opcodes.
module tb_mc_control_fsm;

  localparam logic [4:0] FETCH = 5'd0, DECODE = 5'd1, MEMADR = 5'd2, MEMRD = 5'd3,
                         MEMWB = 5'd4, MEMWR = 5'd5, RTEXEC = 5'd6, RTWB = 5'd7,
                         IEXEC = 5'd8, IWB = 5'd9, BEQ = 5'd10, BNE = 5'd11,
                         JAL = 5'd13, TRAP = 5'd15;

  logic clk, rst, zero, mem_ready;
  logic [5:0] opcode, funct;

  logic a_asa, a_mr, a_mw, a_rw, a_irw, a_iord, a_pcw, a_beq, a_bne, a_done, a_err;
  logic [1:0] a_asb, a_aop, a_pcs, a_rd, a_m2r;
  logic [31:0] a_cnt;
  logic [4:0] a_st;
  logic b_asa, b_mr, b_mw, b_rw, b_irw, b_iord, b_pcw, b_beq, b_bne, b_done, b_err;
  logic [1:0] b_asb, b_aop, b_pcs, b_rd, b_m2r;
  logic [1:0] b_cnt;
  logic [4:0] b_st;

  // strobe vector order: mem_read mem_write reg_write ir_write iord pc_write beq bne
  logic [7:0] a_strb, b_strb;
  assign a_strb = {a_mr, a_mw, a_rw, a_irw, a_iord, a_pcw, a_beq, a_bne};
  assign b_strb = {b_mr, b_mw, b_rw, b_irw, b_iord, b_pcw, b_beq, b_bne};

  int n_cmp = 0;
  int n_mis = 0;

  mc_control_fsm u_a (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .alu_src_a(a_asa), .alu_src_b(a_asb), .alu_op(a_aop), .mem_read(a_mr), .mem_write(a_mw),
    .reg_write(a_rw), .ir_write(a_irw), .iord(a_iord), .pc_write(a_pcw),
    .pc_write_cond_beq(a_beq), .pc_write_cond_bne(a_bne), .pc_src(a_pcs), .reg_dst(a_rd),
    .mem_to_reg(a_m2r), .instr_done(a_done), .retire_cnt(a_cnt), .err(a_err), .state_dbg(a_st)
  );

  mc_control_fsm #(.MEM_TIMEOUT(4), .CNT_W(2), .EN_EXT(1'b0)) u_b (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .alu_src_a(b_asa), .alu_src_b(b_asb), .alu_op(b_aop), .mem_read(b_mr), .mem_write(b_mw),
    .reg_write(b_rw), .ir_write(b_irw), .iord(b_iord), .pc_write(b_pcw),
    .pc_write_cond_beq(b_beq), .pc_write_cond_bne(b_bne), .pc_src(b_pcs), .reg_dst(b_rd),
    .mem_to_reg(b_m2r), .instr_done(b_done), .retire_cnt(b_cnt), .err(b_err), .state_dbg(b_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; sample point is 2 time units after the edge
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    nxt(); nxt();
    // reset state, rst still high
    chk("rst_state", a_st, FETCH);
    chk("rst_strb", a_strb, 8'h00);
    chk("rst_done", a_done, 1'b0);
    chk("rst_cnt", a_cnt, 32'd0);
    chk("rst_err", a_err, 1'b0);

    // add: FETCH DECODE RTEXEC RTWB
    rst = 1'b0; opcode = 6'b000000; funct = 6'b100000; #1;
    chk("add_fetch_st", a_st, FETCH);
    chk("add_fetch_strb", a_strb, 8'b1001_0100);
    chk("add_fetch_asb", a_asb, 2'b01);
    nxt();
    chk("add_dec_st", a_st, DECODE);
    chk("add_dec_asb", a_asb, 2'b11);
    chk("add_dec_strb", a_strb, 8'h00);
    nxt();
    chk("add_ex_st", a_st, RTEXEC);
    chk("add_ex_alu", {a_asa, a_asb, a_aop}, 5'b1_00_10);
    nxt();
    chk("add_wb_st", a_st, RTWB);
    chk("add_wb_strb", a_strb, 8'b0010_0000);
    chk("add_wb_dst", {a_rd, a_m2r}, 4'b01_00);
    chk("add_wb_done", a_done, 1'b1);
    chk("add_wb_cnt", a_cnt, 32'd0);
    nxt();
    chk("add_ret_st", a_st, FETCH);
    chk("add_ret_done", a_done, 1'b0);
    chk("add_ret_cnt", a_cnt, 32'd1);

    // lw with three MEMRD cycles (ready on the third)
    opcode = 6'b100011; funct = 6'd0; #1;
    nxt();
    chk("lw_dec_st", a_st, DECODE);
    nxt();
    chk("lw_adr_st", a_st, MEMADR);
    chk("lw_adr_alu", {a_asa, a_asb, a_aop}, 5'b1_10_00);
    mem_ready = 1'b0; #1;
    nxt();
    chk("lw_rd1_st", a_st, MEMRD);
    chk("lw_rd1_strb", a_strb, 8'b1000_1000);
    nxt();
    chk("lw_rd2_st", a_st, MEMRD);
    chk("lw_rd2_strb", a_strb, 8'b1000_1000);
    nxt();
    mem_ready = 1'b1; #1;
    chk("lw_rd3_st", a_st, MEMRD);
    chk("lw_rd3_strb", a_strb, 8'b1000_1000);
    chk("lw_rd3_done", a_done, 1'b0);
    nxt();
    chk("lw_wb_st", a_st, MEMWB);
    chk("lw_wb_strb", a_strb, 8'b0010_0000);
    chk("lw_wb_dst", {a_rd, a_m2r}, 4'b00_01);
    chk("lw_wb_done", a_done, 1'b1);
    nxt();
    chk("lw_ret_st", a_st, FETCH);
    chk("lw_ret_cnt", a_cnt, 32'd2);

    // beq with zero=1
    opcode = 6'b000100; zero = 1'b1; #1;
    nxt(); nxt();
    chk("beq_st", a_st, BEQ);
    chk("beq_strb", a_strb, 8'b0000_0010);
    chk("beq_pcs_aop", {a_pcs, a_aop}, 4'b01_01);
    chk("beq_done", a_done, 1'b1);
    nxt();
    chk("beq_ret_cnt", a_cnt, 32'd3);

    // bne with zero=0
    opcode = 6'b000101; zero = 1'b0; #1;
    nxt(); nxt();
    chk("bne_st", a_st, BNE);
    chk("bne_strb", a_strb, 8'b0000_0001);
    chk("bne_pcs", a_pcs, 2'b01);
    nxt();
    chk("bne_ret_cnt", a_cnt, 32'd4);
    chk("b_cnt_wrap", b_cnt, 2'd0);

    // jal: A executes, B (extensions off) traps
    opcode = 6'b000011; #1;
    nxt(); nxt();
    chk("jal_st", a_st, JAL);
    chk("jal_strb", a_strb, 8'b0010_0100);
    chk("jal_sel", {a_rd, a_m2r, a_pcs}, 6'b10_10_10);
    chk("b_jal_trap_st", b_st, TRAP);
    chk("b_jal_err", b_err, 1'b1);
    nxt();
    chk("jal_ret_cnt", a_cnt, 32'd5);
    chk("b_trap_hold", b_st, TRAP);
    chk("b_trap_strb", b_strb, 8'h00);

    // timeout: B traps after 4 stalled FETCH cycles
    rst = 1'b1; #1;
    nxt();
    chk("rst_gate_strb", a_strb, 8'h00);
    chk("rst_gate_done", a_done, 1'b0);
    rst = 1'b0; mem_ready = 1'b0; #1;
    chk("b_rst_err", b_err, 1'b0);
    chk("b_rst_st", b_st, FETCH);
    chk("a_rst_cnt", a_cnt, 32'd0);
    chk("a_stall_strb", a_strb, 8'b1000_0000);
    nxt(); nxt(); nxt();
    chk("b_to_c4_st", b_st, FETCH);
    chk("b_to_c4_err", b_err, 1'b0);
    nxt();
    chk("b_to_trap_st", b_st, TRAP);
    chk("b_to_err", b_err, 1'b1);
    chk("a_no_to_st", a_st, FETCH);
    rst = 1'b1; #1;
    nxt();
    rst = 1'b0; mem_ready = 1'b1; #1;
    chk("b_rec_st", b_st, FETCH);
    chk("b_rec_err", b_err, 1'b0);
    chk("b_rec_cnt", b_cnt, 2'd0);

    // illegal opcode traps after DECODE
    opcode = 6'b111111; #1;
    nxt();
    chk("ill_dec_st", a_st, DECODE);
    nxt();
    chk("ill_trap_st", a_st, TRAP);
    chk("ill_err", a_err, 1'b1);
    chk("ill_strb", a_strb, 8'h00);
    nxt();
    chk("ill_hold", {a_st, a_err}, {TRAP, 1'b1});

    // addi on A
    rst = 1'b1; #1;
    nxt();
    rst = 1'b0; opcode = 6'b001000; #1;
    nxt(); nxt();
    chk("addi_ex_st", a_st, IEXEC);
    chk("addi_ex_alu", {a_asa, a_asb, a_aop}, 5'b1_10_11);
    nxt();
    chk("addi_wb_st", a_st, IWB);
    chk("addi_wb", {a_strb, a_rd, a_m2r, a_done}, {8'b0010_0000, 2'b00, 2'b00, 1'b1});
    nxt();

    // sw: reset during a stalled MEMWR
    opcode = 6'b101011; #1;
    nxt(); nxt(); nxt();
    mem_ready = 1'b0; #1;
    chk("sw_wr_st", a_st, MEMWR);
    chk("sw_wr_strb", a_strb, 8'b0100_1000);
    rst = 1'b1; mem_ready = 1'b1; #1;
    chk("sw_rst_strb", a_strb, 8'h00);
    chk("sw_rst_done", a_done, 1'b0);
    nxt();
    rst = 1'b0; mem_ready = 1'b0; #1;
    chk("sw_after_rst_st", a_st, FETCH);
    chk("sw_after_rst_strb", a_strb, 8'b1000_0000);
    chk("sw_after_rst_cnt", a_cnt, 32'd0);

    // sw completing normally retires from MEMWR
    mem_ready = 1'b1; #1;
    nxt(); nxt(); nxt();
    chk("sw_ok_st", a_st, MEMWR);
    chk("sw_ok_done", a_done, 1'b1);
    nxt();
    chk("sw_ok_ret", {a_st, a_cnt}, {FETCH, 32'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
